// File: rtl/rotate_seq_ctrl_pkg.sv
// Shared definitions for the rotate sequencer: register control encoding
// and controller FSM states.
package rotate_seq_ctrl_pkg;

    // Control word for rotate_reg_core
    typedef enum logic [1:0] {
        CTRL_LOAD = 2'b00,
        CTRL_ROR  = 2'b01,
        CTRL_ROL  = 2'b10,
        CTRL_HOLD = 2'b11
    } ctrl_e;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/rotate_seq_ctrl_reg_core.sv
// rotate_reg_core: DW-bit universal rotate register (load / rotate right /
// rotate left / hold), asynchronous active-low reset.
module rotate_reg_core
    import rotate_seq_ctrl_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ctrl,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_reg;
    logic [DW-1:0] q_next;

    // Per-bit next-value mux; right rotate pulls from the bit above,
    // left rotate from the bit below, both wrapping around the word.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_bit
            localparam int UP = (gi + 1) % DW;
            localparam int DN = (gi + DW - 1) % DW;
            assign q_next[gi] = (ctrl == CTRL_LOAD) ? d[gi]     :
                                (ctrl == CTRL_ROR)  ? q_reg[UP] :
                                (ctrl == CTRL_ROL)  ? q_reg[DN] :
                                                      q_reg[gi];
        end
    endgenerate

    // Register state; cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: accepts a word plus rotate direction/distance, rotates
// it one bit per cycle in rotate_reg_core and presents the result with a
// valid/ready handshake.
// Optional feature: define ROT_SHORTCUT_EN to rotate the short way round
// (distances above DW/2 become DW-amt steps in the opposite direction).
module rotate_seq_ctrl
    import rotate_seq_ctrl_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_data,
    input  logic          req_dir,
    input  logic [AW-1:0] req_amt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy
);

    state_e        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          dir_reg, dir_next;
    logic [AW-1:0] steps;
    logic          dir_eff;
    ctrl_e         ctrl_sel;

`ifdef ROT_SHORTCUT_EN
    localparam logic [AW-1:0] HALF = AW'(DW / 2);

    // Long rotations are replaced by the shorter opposite rotation; DW is a
    // power of two, so -amt in AW bits equals DW-amt.
    always_comb begin
        dir_eff = req_dir;
        steps   = req_amt;
        if (req_amt > HALF) begin
            dir_eff = ~req_dir;
            steps   = -req_amt;
        end
    end
`else
    assign dir_eff = req_dir;
    assign steps   = req_amt;
`endif

    // State, step counter and latched direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

    // Next-state, counter and register-control decode
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        ctrl_sel   = CTRL_HOLD;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    ctrl_sel   = CTRL_LOAD;
                    cnt_next   = steps;
                    dir_next   = dir_eff;
                    state_next = (steps != '0) ? ROT : DONE;
                end
            end
            ROT: begin
                ctrl_sel = dir_reg ? CTRL_ROL : CTRL_ROR;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == AW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    rotate_reg_core #(
        .DW (DW)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl_sel),
        .d     (req_data),
        .q     (rsp_data)
    );

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Testbench for rotate_seq_ctrl (DW=4): directed vectors with literal
// expectations plus a transaction-level model checked every cycle.
module tb_rotate_seq_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;

`ifdef ROT_SHORTCUT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data = '0;
    logic          req_dir = 1'b0;
    logic [AW-1:0] req_amt = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_dir   (req_dir),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Reference rotate: everything expressed as a left rotation by k
    function automatic int rot_model(input int d, input int dir, input int amt);
        int k;
        k = dir ? amt : (DW - amt) % DW;
        return ((d << k) | (d >> (DW - k))) & ((1 << DW) - 1);
    endfunction

    function automatic int steps_model(input int amt);
        if (SC && amt > DW / 2) return DW - amt;
        return amt;
    endfunction

    // Transaction-level model: outstanding request, edges left until the
    // response appears, expected result and last delivered word.
    bit m_busy = 1'b0;
    int m_wait = 0;
    int m_res  = 0;
    int m_last = 0;
    int m_acc  = 0;
    int m_done = 0;

    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_rsp_data", rsp_data, 0);
                check("rst_req_ready", req_ready, 1);
                m_busy = 1'b0;
                m_last = 0;
            end else begin
                exp_valid = m_busy && (m_wait == 0);
                check("m_req_ready", req_ready, !m_busy);
                check("m_busy", busy, m_busy);
                check("m_rsp_valid", rsp_valid, exp_valid);
                if (exp_valid) check("m_rsp_data", rsp_data, m_res);
                else if (!m_busy) check("m_idle_data", rsp_data, m_last);
                if (exp_valid && rsp_ready) begin
                    m_busy = 1'b0;
                    m_last = m_res;
                    m_done++;
                end else if (m_busy && m_wait > 0) begin
                    m_wait--;
                end else if (!m_busy && req_valid) begin
                    m_busy = 1'b1;
                    m_wait = steps_model(int'(req_amt));
                    m_res  = rot_model(int'(req_data), int'(req_dir), int'(req_amt));
                    m_acc++;
                end
            end
        end
    end

    // Present a request and return just after the edge that accepts it
    task automatic send(input logic [3:0] d, input logic dir, input logic [1:0] amt,
                        input bit keep);
        bit ok;
        ok = 1'b0;
        req_data  = d;
        req_dir   = dir;
        req_amt   = amt;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Wait for rsp_valid; latency counts edges from the acceptance edge
    task automatic wait_rsp(input string name, input int exp_data, input int exp_lat);
        int lat;
        bit got;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check({name, "_seen"}, got, 1);
        if (got) begin
            check({name, "_data"}, rsp_data, exp_data);
            check({name, "_lat"}, lat, exp_lat);
        end
        $display("txn %s: data=%0h latency=%0d", name, rsp_data, lat);
    endtask

    typedef struct {
        logic [3:0] d;
        logic       dir;
        logic [1:0] amt;
        logic [3:0] exp;
        int         lat_ns;
        int         lat_sc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc0, done0;
        bit idle_ok;

        vecs[0] = '{4'b0001, 1'b1, 2'd1, 4'b0010, 2, 2};
        vecs[1] = '{4'b0001, 1'b1, 2'd3, 4'b1000, 4, 2};
        vecs[2] = '{4'b1011, 1'b0, 2'd0, 4'b1011, 1, 1};
        vecs[3] = '{4'b1000, 1'b0, 2'd3, 4'b0001, 4, 2};
        vecs[4] = '{4'b1101, 1'b0, 2'd1, 4'b1110, 2, 2};

        // Reset state
        #12;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("reset_req_ready", req_ready, 1);

        // Directed vectors with the consumer always ready
        rsp_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].dir, vecs[i].amt, 1'b0);
            wait_rsp($sformatf("vec%0d", i), int'(vecs[i].exp),
                     SC ? vecs[i].lat_sc : vecs[i].lat_ns);
            @(posedge clk);
            #1;
        end

        // Back-pressured response must hold steady
        rsp_ready = 1'b0;
        send(4'b0110, 1'b0, 2'd2, 1'b0);
        wait_rsp("stall", 'h9, 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_data", rsp_data, 'h9);
            check("stall_valid", rsp_valid, 1);
            check("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_busy", busy, 0);
        check("stall_release_ready", req_ready, 1);

        // Reset in the middle of a rotation
        send(4'b0101, 1'b1, 2'd2, 1'b0);
        check("midrot_busy", busy, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(4'b0011, 1'b1, 2'd1, 1'b0);
        wait_rsp("after_abort", 'h6, 2);
        @(posedge clk);
        #1;

        // Back-to-back requests with req_valid held high
        acc0  = m_acc;
        done0 = m_done;
        send(4'b0011, 1'b1, 2'd2, 1'b1);
        send(4'b1101, 1'b0, 2'd1, 1'b1);
        send(4'b1000, 1'b0, 2'd3, 1'b0);
        idle_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_ok = 1'b1;
                break;
            end
        end
        check("b2b_idle", idle_ok, 1);
        check("b2b_accepted", m_acc - acc0, 3);
        check("b2b_completed", m_done - done0, 3);
        check("b2b_last_data", rsp_data, 'h1);
        $display("txn b2b: accepted=%0d completed=%0d", m_acc - acc0, m_done - done0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
